// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// SIGNED_DIV_EN selects two's complement operation in the divider top.
package div_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIXUP, FINISH} state_t;
   localparam int CLA_SLICE = 4;
   localparam int WIDTH_DEF = 16;
   localparam int CNT_W = $clog2(WIDTH_DEF);
endpackage

// File: rtl/cla_subtractor.sv
// W-bit a - b as a + ~b + 1 over chained 4-bit carry-look-ahead slices.
// cout high means no borrow (a >= b).
module cla_subtractor
   import div_pkg::*;
#(
   parameter int W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         cout
);
   localparam int NS = (W + CLA_SLICE - 1) / CLA_SLICE;
   localparam int PW = NS * CLA_SLICE;

   logic [PW-1:0] ax, bx, g, p;
   logic [NS:0]   c;

   // Padding bits are a=0, ~b=1: they only propagate, so cout is unchanged.
   assign ax   = PW'(a);
   assign bx   = ~(PW'(b));
   assign g    = ax & bx;
   assign p    = ax ^ bx;
   assign c[0] = 1'b1;
   assign cout = c[NS];

   for (genvar i = 0; i < NS; i++) begin : g_slice
      logic [3:0] gs, ps;
      logic [4:0] cc;
      assign gs    = g[i*CLA_SLICE +: CLA_SLICE];
      assign ps    = p[i*CLA_SLICE +: CLA_SLICE];
      assign cc[0] = c[i];
      assign cc[1] = gs[0] | (ps[0] & cc[0]);
      assign cc[2] = gs[1] | (ps[1] & gs[0])
                   | (ps[1] & ps[0] & cc[0]);
      assign cc[3] = gs[2] | (ps[2] & gs[1])
                   | (ps[2] & ps[1] & gs[0])
                   | (ps[2] & ps[1] & ps[0] & cc[0]);
      assign cc[4] = gs[3] | (ps[3] & gs[2])
                   | (ps[3] & ps[2] & gs[1])
                   | (ps[3] & ps[2] & ps[1] & gs[0])
                   | (&ps & cc[0]);
      assign c[i+1] = cc[4];
      for (genvar j = 0; j < CLA_SLICE; j++) begin : g_bit
         if (i*CLA_SLICE + j < W) begin : g_out
            assign diff[i*CLA_SLICE + j] = ps[j] ^ cc[j];
         end
      end
   end
endmodule

// File: rtl/sequential_divider_16.sv
// Restoring divider, one quotient bit per cycle, CLA-based trial subtract.
// Define SIGNED_DIV_EN for two's complement operands (adds a FIXUP cycle).
module sequential_divider_16
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);

   state_t         state, state_n;
   logic [CW-1:0]  cnt;
   logic [WIDTH:0] rem_r, shifted, rem_nx;
   logic [WIDTH:0] sub_a, sub_b, sub_diff;
   logic [WIDTH-1:0] q_r, q_nx, dsr_r;
   logic           sub_cout, last;

   assign shifted = (rem_r << 1) | (WIDTH+1)'(q_r[WIDTH-1]);
   assign rem_nx  = sub_cout ? sub_diff : shifted;
   assign q_nx    = {q_r[WIDTH-2:0], sub_cout};
   assign last    = (cnt == CW'(WIDTH-1));

`ifdef SIGNED_DIV_EN
   logic           q_neg, r_neg, rneg_nb;
   logic [WIDTH:0] rneg_diff;
   // FIXUP borrows the trial subtractor to form 0 - quotient.
   assign sub_a = (state == FIXUP) ? '0 : shifted;
   assign sub_b = (state == FIXUP) ? {1'b0, q_r} : {1'b0, dsr_r};

   cla_subtractor #(.W(WIDTH+1)) u_neg (
      .a    ({(WIDTH+1){1'b0}}),
      .b    (rem_r),
      .diff (rneg_diff),
      .cout (rneg_nb)
   );
`else
   assign sub_a = shifted;
   assign sub_b = {1'b0, dsr_r};
`endif

   cla_subtractor #(.W(WIDTH+1)) u_sub (
      .a    (sub_a),
      .b    (sub_b),
      .diff (sub_diff),
      .cout (sub_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:   if (start) state_n = (divisor == '0) ? FINISH : RUN;
`ifdef SIGNED_DIV_EN
         RUN:    if (last) state_n = FIXUP;
`else
         RUN:    if (last) state_n = FINISH;
`endif
         FIXUP:  state_n = FINISH;
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dsr_r       <= '0;
`ifdef SIGNED_DIV_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         busy <= (state_n != IDLE);
         done <= (state_n == FINISH);
         unique case (state)
            IDLE: if (start) begin
               div_by_zero <= 1'b0;
               cnt         <= '0;
               rem_r       <= '0;
               if (divisor == '0) begin
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
`ifdef SIGNED_DIV_EN
                  q_r   <= dividend[WIDTH-1] ? ~dividend + 1'b1 : dividend;
                  dsr_r <= divisor[WIDTH-1] ? ~divisor + 1'b1 : divisor;
                  q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg <= dividend[WIDTH-1];
`else
                  q_r   <= dividend;
                  dsr_r <= divisor;
`endif
               end
            end
            RUN: begin
               rem_r <= rem_nx;
               q_r   <= q_nx;
               cnt   <= cnt + 1'b1;
`ifndef SIGNED_DIV_EN
               if (last) begin
                  quotient  <= q_nx;
                  remainder <= rem_nx[WIDTH-1:0];
               end
`endif
            end
`ifdef SIGNED_DIV_EN
            FIXUP: begin
               quotient  <= q_neg ? sub_diff[WIDTH-1:0] : q_r;
               // Negating a zero remainder is a no-op; skip it.
               remainder <= (r_neg && !rneg_nb) ? rneg_diff[WIDTH-1:0]
                                                : rem_r[WIDTH-1:0];
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sequential_divider_16.sv
// Randomized self-checking bench for sequential_divider_16.
// Build with +define+SIGNED_DIV_EN to exercise the signed variant.
module tb_sequential_divider_16;
   localparam int W = 16;
`ifdef SIGNED_DIV_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int tests = 0;
   int fails = 0;

   sequential_divider_16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z, output int lat);
      int sa, sb, qi, ri;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1; lat = 1;
      end else begin
         z = 1'b0; lat = LAT;
`ifdef SIGNED_DIV_EN
         sa = int'($signed(a)); sb = int'($signed(b));
`else
         sa = int'(a); sb = int'(b);
`endif
         qi = sa / sb; ri = sa % sb;
         q = qi[W-1:0]; r = ri[W-1:0];
      end
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat,
                        output logic busy_ok, output logic pulse_ok);
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; busy_ok = 1'b1;
      while (!done && lat < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!busy) busy_ok = 1'b0;
      q = quotient; r = remainder; z = div_by_zero;
      @(negedge clk);
      pulse_ok = !done && !busy;
   endtask

   task automatic test_reset;
      #12;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
      end
      tests++;
      if (quotient !== '0 || remainder !== '0) begin
         fails++; $display("FAIL reset_data q=%h r=%h want 0 0", quotient, remainder);
      end
      tests++;
      if (div_by_zero !== 1'b0) begin
         fails++; $display("FAIL reset_dbz got %b want 0", div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [3] = '{16'd100, 16'hFFFF, 16'h0003};
      logic [W-1:0] tb [3] = '{16'd7, 16'h0001, 16'h000A};
      logic [W-1:0] q, r, eq, er;
      logic z, ez, bok, pok;
      int lat, el;
      for (int i = 0; i < 3; i++) begin
         model(ta[i], tb[i], eq, er, ez, el);
         do_op(ta[i], tb[i], q, r, z, lat, bok, pok);
         tests++;
         if (q !== eq || r !== er || z !== ez) begin
            fails++;
            $display("FAIL directed_%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, q, r, z, eq, er, ez);
         end
         tests++;
         if (lat !== el || !bok || !pok) begin
            fails++;
            $display("FAIL directed_timing_%0d lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                     i, lat, bok, pok, el);
         end
      end
`ifndef SIGNED_DIV_EN
      do_op(16'd100, 16'd7, q, r, z, lat, bok, pok);
      tests++;
      if (q !== 16'd14 || r !== 16'd2 || lat !== 17) begin
         fails++;
         $display("FAIL div_100_7 got q=%0d r=%0d lat=%0d want 14 2 17", q, r, lat);
      end
`endif
   endtask

   task automatic test_div_zero;
      logic [W-1:0] q, r;
      logic z, bok, pok;
      int lat;
      do_op(16'd5, 16'd0, q, r, z, lat, bok, pok);
      tests++;
      if (q !== 16'hFFFF || r !== 16'd5 || z !== 1'b1) begin
         fails++; $display("FAIL div_zero got q=%h r=%h z=%b want ffff 0005 1", q, r, z);
      end
      tests++;
      if (lat !== 1 || !bok || !pok) begin
         fails++; $display("FAIL div_zero_timing lat=%0d bok=%b pok=%b want 1 1 1", lat, bok, pok);
      end
      do_op(16'd100, 16'd7, q, r, z, lat, bok, pok);
      tests++;
      if (z !== 1'b0) begin
         fails++; $display("FAIL dbz_clear got %b want 0", z);
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b, q, r, eq, er;
      logic z, ez, bok, pok;
      int lat, el;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         if (i % 8 == 0) b = '0;
         else if (i % 3 == 0) b = W'($urandom_range(1, 255));
         else b = W'($urandom);
         model(a, b, eq, er, ez, el);
         do_op(a, b, q, r, z, lat, bok, pok);
         tests++;
         if (q !== eq || r !== er || z !== ez || lat !== el || !bok || !pok) begin
            fails++;
            $display("FAIL random_%0d %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                     i, a, b, q, r, z, lat, eq, er, ez, el);
         end
      end
   endtask

   task automatic test_restart_ignored;
      logic [W-1:0] eq, er;
      logic ez, gap;
      int k, el;
      model(16'd100, 16'd7, eq, er, ez, el);
      @(negedge clk);
      dividend = 16'd100; divisor = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0; k = 1; gap = 1'b0;
      while (!done && k < 60) begin
         if (!busy) gap = 1'b1;
         if (k == 5) begin dividend = 16'd9; divisor = 16'd3; start = 1'b1; end
         @(negedge clk);
         k++;
         if (k == 6) start = 1'b0;
      end
      tests++;
      if (quotient !== eq || remainder !== er || k !== el || gap) begin
         fails++;
         $display("FAIL restart_ignored got q=%h r=%h lat=%0d gap=%b want q=%h r=%h lat=%0d gap=0",
                  quotient, remainder, k, gap, eq, er, el);
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      logic [W-1:0] q, r, eq, er;
      logic z, ez, bok, pok, seen;
      int lat, el;
      @(negedge clk);
      dividend = 16'd1234; divisor = 16'd56; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 ||
          remainder !== '0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL abort_reset got busy=%b done=%b q=%h r=%h z=%b want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      seen = 1'b0;
      repeat (2) begin @(negedge clk); if (done) seen = 1'b1; end
      rst_n = 1'b1;
      repeat (20) begin @(negedge clk); if (done || busy) seen = 1'b1; end
      tests++;
      if (seen) begin
         fails++; $display("FAIL abort_no_done got activity=1 want 0");
      end
      model(16'd100, 16'd7, eq, er, ez, el);
      do_op(16'd100, 16'd7, q, r, z, lat, bok, pok);
      tests++;
      if (q !== eq || r !== er || lat !== el) begin
         fails++;
         $display("FAIL after_abort got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                  q, r, lat, eq, er, el);
      end
   endtask

   task automatic test_held_start;
      logic [W-1:0] eq, er;
      logic ez;
      int k, el;
      @(negedge clk);
      dividend = 16'd200; divisor = 16'd9; start = 1'b1;
      @(negedge clk);
      k = 1;
      while (!done && k < 60) begin @(negedge clk); k++; end
      model(16'd200, 16'd9, eq, er, ez, el);
      tests++;
      if (quotient !== eq || remainder !== er || k !== el) begin
         fails++;
         $display("FAIL held_first got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                  quotient, remainder, k, eq, er, el);
      end
      dividend = 16'd77; divisor = 16'd5;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL held_idle_gap busy=%b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL held_accept busy=%b want 1", busy);
      end
      k = 1;
      while (!done && k < 60) begin @(negedge clk); k++; end
      model(16'd77, 16'd5, eq, er, ez, el);
      tests++;
      if (quotient !== eq || remainder !== er || k !== el) begin
         fails++;
         $display("FAIL held_second got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                  quotient, remainder, k, eq, er, el);
      end
      @(negedge clk);
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed;
      logic [W-1:0] q, r;
      logic z, bok, pok;
      int lat;
      do_op(16'hFFF9, 16'h0002, q, r, z, lat, bok, pok);
      tests++;
      if (q !== 16'hFFFD || r !== 16'hFFFF || lat !== 18) begin
         fails++;
         $display("FAIL signed_m7_2 got q=%h r=%h lat=%0d want fffd ffff 18", q, r, lat);
      end
      do_op(16'h8000, 16'hFFFF, q, r, z, lat, bok, pok);
      tests++;
      if (q !== 16'h8000 || r !== 16'h0000 || z !== 1'b0) begin
         fails++;
         $display("FAIL signed_minneg got q=%h r=%h z=%b want 8000 0000 0", q, r, z);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_restart_ignored();
      test_held_start();
      test_abort();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
